// File: rtl/lii_out_arbiter.sv
// Round-robin arbiter sharing one LII phy output channel between N kernel streams.
// A grant lasts one packet or MAX_BURST beats; the output side is a one-entry registered buffer.
module lii_out_arbiter #(
    parameter int N         = 4,
    parameter int PW        = 64,
    parameter int MAX_BURST = 16,
    parameter int SRC_BASE  = 0
) (
    input  logic                                aclk,
    input  logic                                arst,
    input  logic [N*PW-1:0]                     req_tdata,
    input  logic [N-1:0]                        req_tvalid,
    output logic [N-1:0]                        req_tready,
    input  logic [N-1:0]                        req_tlast,
    input  logic [N*8-1:0]                      req_dst,
    output logic [PW-1:0]                       lii_out_tdata,
    output logic                                lii_out_tvalid,
    input  logic                                lii_out_tready,
    output logic [7:0]                          lii_out_src,
    output logic [7:0]                          lii_out_dst,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant_idx,
    output logic                                busy
);

    localparam int GW = (N > 1) ? $clog2(N) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] LAST_CNT = BW'(MAX_BURST - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state;
    logic [GW-1:0] rr_ptr;
    logic [BW-1:0] beat_cnt;
    logic [GW-1:0] pick;
    logic [GW-1:0] idx;
    logic          any_req;
    logic          can_accept;
    logic          xfer;
    logic          release_now;

    assign can_accept  = !lii_out_tvalid || lii_out_tready;
    assign xfer        = (state == GRANT) && req_tvalid[grant_idx] && can_accept;
    assign release_now = xfer && (req_tlast[grant_idx] || beat_cnt == LAST_CNT);
    assign busy        = (state == GRANT);

    // Ready is withheld during reset so no requester sees a handshake that gets discarded.
    always_comb begin
        req_tready = '0;
        if (state == GRANT && !arst)
            req_tready[grant_idx] = can_accept;
    end

    // Scan rr_ptr+1, rr_ptr+2, ... so the previous owner is considered last.
    always_comb begin
        pick    = rr_ptr;
        any_req = 1'b0;
        idx     = '0;
        for (int k = 1; k <= N; k++) begin
            idx = GW'((int'(rr_ptr) + k) % N);
            if (!any_req && req_tvalid[idx]) begin
                pick    = idx;
                any_req = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            state          <= IDLE;
            rr_ptr         <= GW'(N - 1);
            beat_cnt       <= '0;
            grant_idx      <= '0;
            lii_out_tvalid <= 1'b0;
            lii_out_tdata  <= '0;
            lii_out_src    <= '0;
            lii_out_dst    <= '0;
        end else begin
            if (xfer) begin
                lii_out_tvalid <= 1'b1;
                lii_out_tdata  <= req_tdata[int'(grant_idx)*PW +: PW];
                lii_out_src    <= 8'(SRC_BASE) + 8'(grant_idx);
                lii_out_dst    <= req_dst[int'(grant_idx)*8 +: 8];
            end else if (lii_out_tready) begin
                lii_out_tvalid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (any_req) begin
                        state     <= GRANT;
                        grant_idx <= pick;
                        beat_cnt  <= '0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state    <= IDLE;
                        rr_ptr   <= grant_idx;
                        beat_cnt <= '0;
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt + BW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
